bip_run_controller: RTL and testbench
=====================================

# bip_run_controller

Host-side sequencer for the BIP core. Receives a program over a byte stream, writes it into BIP program memory, releases the core from reset, counts execution cycles until the core raises done (or a watchdog expires), then returns a status/cycle-count report over a byte stream. It sits between the host link (UART or equivalent byte interface) and the BIP top level, and owns the core's reset and the program-memory write port.

## Interface

- ADDRESS_BITS, 11, program-memory address width; must equal the core's address width.
- DATA_BITS, 16, instruction width (5-bit opcode plus 11-bit operand).
- CYCLE_BITS, 32, cycle-counter width; also the watchdog limit of 2^CYCLE_BITS-1.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_start  in  1  begin a load/run session; sampled only in IDLE.
- i_rx_data  in  8  byte from host.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  controller accepts a byte; a transfer occurs when valid&&ready.
- o_tx_data  out  8  report byte to host.
- o_tx_valid  out  1  o_tx_data valid; held until accepted.
- i_tx_ready  in  1  host accepts report byte.
- i_bip_done  in  1  done flag from the BIP core.
- o_bip_rst  out  1  active-low reset to BIP core; high only in RUN.
- o_prog_we  out  1  program-memory write strobe, one cycle per instruction.
- o_prog_addr  out  ADDRESS_BITS  program-memory write address.
- o_prog_data  out  DATA_BITS  program-memory write data.
- o_cycle_count  out  CYCLE_BITS  last measured cycle count; held until next i_start.
- o_busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, LEN_LO, LEN_HI, INSTR_LO, INSTR_HI, RUN, REPORT.
- IDLE: o_rx_ready=0, o_bip_rst=0. i_start=1 -> LEN_LO, clears o_cycle_count and write address.
- LEN_LO/LEN_HI: accept two bytes forming 16-bit instruction count N, low byte first. N > 2^ADDRESS_BITS is clamped to 2^ADDRESS_BITS; excess host bytes are not consumed. N=0 -> RUN directly (existing memory contents run).
- INSTR_LO/INSTR_HI: each instruction is two bytes, low byte first. On INSTR_HI handshake: registered write, o_prog_we=1 next cycle with o_prog_data={hi,lo}, o_prog_addr=current index; index increments after the write. After write N-1 -> RUN.
- RUN: o_bip_rst=1, o_rx_ready=0. Counter starts at 0, increments each cycle i_bip_done=0. i_bip_done=1 -> REPORT with status 0x00, count frozen. Counter reaching 2^CYCLE_BITS-1 -> REPORT with status 0x01 (timeout).
- REPORT: o_bip_rst=0. Sends status byte then CYCLE_BITS/8 count bytes, LSB first (5 bytes at default). o_tx_data stable while o_tx_valid=1 and i_tx_ready=0. After last handshake -> IDLE.
- i_start outside IDLE ignored. i_rx_valid outside LEN/INSTR states ignored (no ready).
- Reset mid-operation: any state -> IDLE; partially loaded memory is not cleared; core held in reset.

## Timing

- Reset values: state IDLE, o_rx_ready 0, o_tx_valid 0, o_tx_data 0x00, o_bip_rst 0, o_prog_we 0, o_prog_addr 0, o_prog_data 0, o_cycle_count 0, o_busy 0.
- All outputs registered. o_rx_ready is 1 throughout LEN_LO..INSTR_HI; one byte per cycle maximum throughput.
- o_prog_we pulses exactly one cycle, the cycle after the INSTR_HI handshake.
- o_bip_rst rises the cycle after the last o_prog_we pulse (or two cycles after the LEN_HI handshake when N=0).
- i_bip_done sampled each RUN cycle; o_bip_rst falls and o_tx_valid rises the cycle after done is sampled high.
- Done in first RUN cycle -> count 0. o_cycle_count equals number of RUN cycles with done low.
- i_bip_done and watchdog limit in the same cycle: done wins, status 0x00.

## Structure

- Package bip_loader_pkg: state enumeration, status codes (STATUS_DONE=0x00, STATUS_TIMEOUT=0x01), length-header byte count, report byte count derived from CYCLE_BITS.
- Sub-module byte_tx_serializer: loads {count,status} word, shifts out bytes with valid/ready handshake, flags completion. Remaining FSM, load assembly and counter in top module.

## Test plan

- Load N=3 (bytes 03 00, then 01 08, 02 10, 00 00) -> three o_prog_we pulses, addr 0,1,2, data 0x0801,0x1002,0x0000; o_bip_rst rises one cycle after third pulse.
- Model core asserting done 10 cycles after release -> o_cycle_count=10, report bytes 00 0A 00 00 00, then IDLE.
- N=0 -> no writes, RUN entered, report produced normally.
- Host stalls i_tx_ready low 5 cycles per byte and toggles i_rx_valid randomly -> no byte lost or duplicated, o_tx_data stable while stalled.
- CYCLE_BITS=8, done never asserted -> report 01 FF after 255 RUN cycles, core back in reset.
- rst low during INSTR_HI and during RUN -> next cycle IDLE, all outputs at reset values, new i_start completes a full session.

Source files
------------

// File: rtl/bip_loader_pkg.sv
// Shared types and constants for the BIP host-side loader/run controller.
package bip_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_INSTR_LO,
    ST_INSTR_HI,
    ST_RUN,
    ST_REPORT
  } state_t;

  localparam logic [7:0] STATUS_DONE    = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

  localparam int LEN_HEADER_BYTES = 2;

  // Report is one status byte followed by the cycle count, LSB first.
  function automatic int report_bytes(input int cycle_bits);
    return cycle_bits / 8 + 1;
  endfunction

endpackage

// File: rtl/byte_tx_serializer.sv
// Shifts a loaded multi-byte word out LSB-first over a valid/ready byte link
// and pulses finished on the handshake of the final byte.
module byte_tx_serializer #(
  parameter int BYTES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [8*BYTES-1:0] load_word,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               finished
);

  localparam int CW = $clog2(BYTES + 1);

  logic [8*BYTES-1:0] shift_reg;
  logic [CW-1:0]      left_reg;
  logic               fire;

  assign fire     = tx_valid && tx_ready;
  assign finished = fire && (left_reg == CW'(1));
  assign tx_data  = shift_reg[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg <= '0;
      left_reg  <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_word;
      left_reg  <= CW'(BYTES);
      tx_valid  <= 1'b1;
    end else if (fire) begin
      shift_reg <= shift_reg >> 8;
      left_reg  <= left_reg - CW'(1);
      tx_valid  <= (left_reg != CW'(1));
    end
  end

endmodule

// File: rtl/bip_run_controller.sv
// Loads a BIP program from a host byte stream, runs the core under a cycle
// counter/watchdog, then reports status and cycle count back to the host.
module bip_run_controller
  import bip_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int CYCLE_BITS   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  input  logic                    i_bip_done,
  output logic                    o_bip_rst,
  output logic                    o_prog_we,
  output logic [ADDRESS_BITS-1:0] o_prog_addr,
  output logic [DATA_BITS-1:0]    o_prog_data,
  output logic [CYCLE_BITS-1:0]   o_cycle_count,
  output logic                    o_busy
);

  localparam int REPORT_BYTES = report_bytes(CYCLE_BITS);
  localparam int LW           = ADDRESS_BITS + 1;
  localparam logic [LW-1:0] LEN_LIMIT = LW'(1) << ADDRESS_BITS;
  // One below the all-ones limit: the increment from here lands on the limit.
  localparam logic [CYCLE_BITS-1:0] WATCHDOG_LAST = ~CYCLE_BITS'(1);

  state_t                  state_reg, state_next;
  logic [7:0]              lo_reg;
  logic [LW-1:0]           left_reg;
  logic [ADDRESS_BITS-1:0] index_reg;
  logic [CYCLE_BITS-1:0]   count_next;
  logic [7:0]              status_next;
  logic [15:0]             len_word;
  logic [LW-1:0]           len_clamped;
  logic rx_fire, counting, timeout, load_report, tx_finished;
  logic rx_ready_next, bip_rst_next, busy_next;

  assign rx_fire     = i_rx_valid && o_rx_ready;
  assign len_word    = {i_rx_data, lo_reg};
  assign len_clamped = (len_word > 16'(LEN_LIMIT)) ? LEN_LIMIT : len_word[LW-1:0];

  // Cycles are only counted once the core is actually out of reset.
  assign counting    = (state_reg == ST_RUN) && o_bip_rst;
  assign timeout     = counting && !i_bip_done && (o_cycle_count == WATCHDOG_LAST);
  assign count_next  = (counting && !i_bip_done) ? o_cycle_count + CYCLE_BITS'(1) : o_cycle_count;
  assign status_next = i_bip_done ? STATUS_DONE : STATUS_TIMEOUT;
  assign load_report = (state_reg == ST_RUN) && (state_next == ST_REPORT);

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (i_start) state_next = ST_LEN_LO;
      ST_LEN_LO:   if (rx_fire) state_next = ST_LEN_HI;
      ST_LEN_HI:   if (rx_fire) state_next = (len_clamped == '0) ? ST_RUN : ST_INSTR_LO;
      ST_INSTR_LO: if (rx_fire) state_next = ST_INSTR_HI;
      ST_INSTR_HI: if (rx_fire) state_next = (left_reg == LW'(1)) ? ST_RUN : ST_INSTR_LO;
      ST_RUN:      if (counting && (i_bip_done || timeout)) state_next = ST_REPORT;
      ST_REPORT:   if (tx_finished) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // The first RUN cycle keeps the core in reset so release trails the last write.
  always_comb begin
    rx_ready_next = state_next inside {ST_LEN_LO, ST_LEN_HI, ST_INSTR_LO, ST_INSTR_HI};
    bip_rst_next  = (state_reg == ST_RUN) && (state_next == ST_RUN);
    busy_next     = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_rx_ready    <= 1'b0;
      o_bip_rst     <= 1'b0;
      o_busy        <= 1'b0;
      o_prog_we     <= 1'b0;
      o_prog_addr   <= '0;
      o_prog_data   <= '0;
      o_cycle_count <= '0;
      lo_reg        <= '0;
      left_reg      <= '0;
      index_reg     <= '0;
    end else begin
      o_rx_ready <= rx_ready_next;
      o_bip_rst  <= bip_rst_next;
      o_busy     <= busy_next;
      o_prog_we  <= 1'b0;
      if ((state_reg == ST_IDLE) && i_start) begin
        o_cycle_count <= '0;
        index_reg     <= '0;
        o_prog_addr   <= '0;
      end else begin
        o_cycle_count <= count_next;
      end
      if (rx_fire) begin
        case (state_reg)
          ST_LEN_LO, ST_INSTR_LO: lo_reg <= i_rx_data;
          ST_LEN_HI:              left_reg <= len_clamped;
          ST_INSTR_HI: begin
            o_prog_we   <= 1'b1;
            o_prog_addr <= index_reg;
            o_prog_data <= DATA_BITS'({i_rx_data, lo_reg});
            index_reg   <= index_reg + ADDRESS_BITS'(1);
            left_reg    <= left_reg - LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  byte_tx_serializer #(.BYTES(REPORT_BYTES)) tx_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load_report),
    .load_word ({count_next, status_next}),
    .tx_data   (o_tx_data),
    .tx_valid  (o_tx_valid),
    .tx_ready  (i_tx_ready),
    .finished  (tx_finished)
  );

endmodule

// File: tb/tb_bip_run_controller.sv
// Directed bench for bip_run_controller: default instance plus an 8-bit
// cycle-counter instance for watchdog cases.
`timescale 1ns/1ps
module tb_bip_run_controller;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_rx_valid, i_tx_ready, i_bip_done;
  logic [7:0] i_rx_data;
  logic o_rx_ready, o_tx_valid, o_bip_rst, o_prog_we, o_busy;
  logic [7:0] o_tx_data;
  logic [10:0] o_prog_addr;
  logic [15:0] o_prog_data;
  logic [31:0] o_cycle_count;

  logic i_start8, i_rx_valid8, i_tx_ready8, i_bip_done8;
  logic [7:0] i_rx_data8;
  logic o_rx_ready8, o_tx_valid8, o_bip_rst8, o_prog_we8, o_busy8;
  logic [7:0] o_tx_data8;
  logic [10:0] o_prog_addr8;
  logic [15:0] o_prog_data8;
  logic [7:0] o_cycle_count8;

  int checks, errors;
  int cyc = 0;
  int run8 = 0;
  int release_cyc, last_hs_cyc;
  bit tmo;
  int unstable;
  logic [7:0] rpt[$];
  logic [10:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int wr_cyc_q[$];

  always #5 clk = ~clk;

  bip_run_controller dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .i_bip_done(i_bip_done),
    .o_bip_rst(o_bip_rst), .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr),
    .o_prog_data(o_prog_data), .o_cycle_count(o_cycle_count), .o_busy(o_busy)
  );

  bip_run_controller #(.CYCLE_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .i_start(i_start8), .i_rx_data(i_rx_data8),
    .i_rx_valid(i_rx_valid8), .o_rx_ready(o_rx_ready8), .o_tx_data(o_tx_data8),
    .o_tx_valid(o_tx_valid8), .i_tx_ready(i_tx_ready8), .i_bip_done(i_bip_done8),
    .o_bip_rst(o_bip_rst8), .o_prog_we(o_prog_we8), .o_prog_addr(o_prog_addr8),
    .o_prog_data(o_prog_data8), .o_cycle_count(o_cycle_count8), .o_busy(o_busy8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_prog_we === 1'b1) begin
      wr_addr_q.push_back(o_prog_addr);
      wr_data_q.push_back(o_prog_data);
      wr_cyc_q.push_back(cyc);
    end
    if (o_bip_rst8 === 1'b1) run8 <= run8 + 1;
  end

  // ---------------- stimulus drivers (no checking) ----------------
  task automatic start_session();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    i_rx_valid = 1'b0;
    repeat (gap) begin
      i_rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (o_rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_rx_ready !== 1'b1) tmo = 1'b1;
    @(posedge clk); #1;
    last_hs_cyc = cyc;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_release();
    int n = 0;
    while (o_bip_rst !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_bip_rst !== 1'b1) tmo = 1'b1;
    release_cyc = cyc;
  endtask

  task automatic run_core(input int done_after);
    wait_release();
    repeat (done_after) begin @(posedge clk); #1; end
    i_bip_done = 1'b1;
    @(posedge clk); #1;
    i_bip_done = 1'b0;
  endtask

  task automatic recv_report(input int nbytes, input int stall);
    logic [7:0] hold;
    int n;
    rpt.delete();
    unstable = 0;
    for (int i = 0; i < nbytes; i++) begin
      n = 0;
      while (o_tx_valid !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (o_tx_valid !== 1'b1) tmo = 1'b1;
      repeat (stall) begin
        hold = o_tx_data;
        @(posedge clk); #1;
        if (o_tx_data !== hold || o_tx_valid !== 1'b1) unstable++;
      end
      i_tx_ready = 1'b1;
      rpt.push_back(o_tx_data);
      @(posedge clk); #1;
      i_tx_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", o_rx_ready); end
    checks++; if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", o_tx_valid, o_tx_data); end
    checks++; if (o_bip_rst !== 1'b0) begin errors++; $display("FAIL reset_bip_rst: got %b expected 0", o_bip_rst); end
    checks++; if (o_prog_we !== 1'b0 || o_prog_addr !== 11'd0 || o_prog_data !== 16'h0000) begin errors++; $display("FAIL reset_prog: got we=%b addr=%h data=%h expected 0/0/0", o_prog_we, o_prog_addr, o_prog_data); end
    checks++; if (o_cycle_count !== 32'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL reset_count_busy: got count=%0d busy=%b expected 0/0", o_cycle_count, o_busy); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_rx_ready !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL idle_ignores_rx: got ready=%b busy=%b expected 0/0", o_rx_ready, o_busy); end
    i_rx_valid = 1'b0;
  endtask

  task automatic test_load_n3();
    logic [7:0] bytes_in [8];
    logic [7:0] exp_b [5];
    logic [15:0] exp_d [3];
    int base;
    bytes_in = '{8'h03, 8'h00, 8'h01, 8'h08, 8'h02, 8'h10, 8'h00, 8'h00};
    exp_b    = '{8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
    exp_d    = '{16'h0801, 16'h1002, 16'h0000};
    tmo  = 1'b0;
    base = wr_addr_q.size();
    start_session();
    checks++; if (o_busy !== 1'b1 || o_rx_ready !== 1'b1) begin errors++; $display("FAIL n3_session_open: got busy=%b ready=%b expected 1/1", o_busy, o_rx_ready); end
    for (int i = 0; i < 8; i++) send_byte(bytes_in[i], 0);
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL n3_ready_drop: got %b expected 0", o_rx_ready); end
    run_core(10);
    checks++; if (wr_addr_q.size() - base !== 3) begin errors++; $display("FAIL n3_write_count: got %0d expected 3", wr_addr_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr_q[base+i] !== 11'(i) || wr_data_q[base+i] !== exp_d[i]) begin
        errors++; $display("FAIL n3_write%0d: got addr=%0d data=%h expected addr=%0d data=%h", i, wr_addr_q[base+i], wr_data_q[base+i], i, exp_d[i]);
      end
    end
    checks++; if (release_cyc !== wr_cyc_q[base+2] + 1) begin errors++; $display("FAIL n3_release_timing: got cycle %0d expected %0d", release_cyc, wr_cyc_q[base+2] + 1); end
    checks++; if (o_bip_rst !== 1'b0 || o_tx_valid !== 1'b1 || o_cycle_count !== 32'd10) begin errors++; $display("FAIL n3_done_response: got bip_rst=%b tx_valid=%b count=%0d expected 0/1/10", o_bip_rst, o_tx_valid, o_cycle_count); end
    recv_report(5, 0);
    checks++; if (rpt.size() !== 5) begin errors++; $display("FAIL n3_report_len: got %0d expected 5", rpt.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rpt[i] !== exp_b[i]) begin errors++; $display("FAIL n3_report_byte%0d: got %h expected %h", i, rpt[i], exp_b[i]); end
    end
    checks++; if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin errors++; $display("FAIL n3_back_to_idle: got busy=%b tx_valid=%b expected 0/0", o_busy, o_tx_valid); end
    checks++; if (tmo) begin errors++; $display("FAIL n3_handshake_timeout: got timeout expected none"); end
  endtask

  task automatic test_zero_length();
    logic [7:0] exp_b [5];
    int base;
    exp_b = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    tmo  = 1'b0;
    base = wr_addr_q.size();
    start_session();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    run_core(3);
    checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL n0_no_writes: got %0d writes expected 0", wr_addr_q.size() - base); end
    checks++; if (release_cyc !== last_hs_cyc + 1) begin errors++; $display("FAIL n0_release_timing: got cycle %0d expected %0d", release_cyc, last_hs_cyc + 1); end
    recv_report(5, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rpt[i] !== exp_b[i]) begin errors++; $display("FAIL n0_report_byte%0d: got %h expected %h", i, rpt[i], exp_b[i]); end
    end
    checks++; if (tmo || o_busy !== 1'b0) begin errors++; $display("FAIL n0_finish: got timeout=%b busy=%b expected 0/0", tmo, o_busy); end
  endtask

  task automatic test_stall();
    logic [7:0] bytes_in [6];
    logic [7:0] exp_b [5];
    int base;
    bytes_in = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    exp_b    = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    tmo  = 1'b0;
    base = wr_addr_q.size();
    start_session();
    for (int i = 0; i < 6; i++) send_byte(bytes_in[i], int'($urandom_range(0, 3)));
    run_core(7);
    checks++; if (wr_addr_q.size() - base !== 2) begin errors++; $display("FAIL stall_write_count: got %0d expected 2", wr_addr_q.size() - base); end
    checks++; if (wr_data_q[base] !== 16'h1234 || wr_data_q[base+1] !== 16'h5678 || wr_addr_q[base+1] !== 11'd1) begin
      errors++; $display("FAIL stall_write_data: got %h,%h@%0d expected 1234,5678@1", wr_data_q[base], wr_data_q[base+1], wr_addr_q[base+1]);
    end
    recv_report(5, 5);
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_tx_stable: got %0d unstable cycles expected 0", unstable); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rpt[i] !== exp_b[i]) begin errors++; $display("FAIL stall_report_byte%0d: got %h expected %h", i, rpt[i], exp_b[i]); end
    end
    checks++; if (tmo || o_busy !== 1'b0) begin errors++; $display("FAIL stall_finish: got timeout=%b busy=%b expected 0/0", tmo, o_busy); end
  endtask

  task automatic test_len_clamp();
    logic [15:0] w;
    int base;
    tmo  = 1'b0;
    base = wr_addr_q.size();
    start_session();
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    for (int i = 0; i < 2048; i++) begin
      w = 16'(i);
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
    end
    checks++; if (o_rx_ready !== 1'b0) begin errors++; $display("FAIL clamp_ready_drop: got %b expected 0", o_rx_ready); end
    run_core(0);
    checks++; if (wr_addr_q.size() - base !== 2048) begin errors++; $display("FAIL clamp_write_count: got %0d expected 2048", wr_addr_q.size() - base); end
    checks++; if (wr_addr_q[base+2047] !== 11'd2047 || wr_data_q[base+2047] !== 16'd2047) begin
      errors++; $display("FAIL clamp_last_write: got addr=%0d data=%h expected 2047/07ff", wr_addr_q[base+2047], wr_data_q[base+2047]);
    end
    checks++; if (o_cycle_count !== 32'd0 || o_tx_valid !== 1'b1) begin errors++; $display("FAIL clamp_done_first_cycle: got count=%0d tx_valid=%b expected 0/1", o_cycle_count, o_tx_valid); end
    recv_report(5, 0);
    checks++; if (rpt[0] !== 8'h00 || rpt[1] !== 8'h00 || o_busy !== 1'b0 || tmo) begin
      errors++; $display("FAIL clamp_report: got %h %h busy=%b timeout=%b expected 00 00 0 0", rpt[0], rpt[1], o_busy, tmo);
    end
  endtask

  task automatic test_watchdog();
    int n = 0;
    int base;
    logic [7:0] b0, b1;
    i_start8 = 1'b1;
    @(posedge clk); #1;
    i_start8   = 1'b0;
    i_rx_data8 = 8'h00;
    i_rx_valid8 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    i_rx_valid8 = 1'b0;
    base = run8;
    while (o_tx_valid8 !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (o_tx_valid8 !== 1'b1) begin errors++; $display("FAIL wdog_report_valid: got %b expected 1", o_tx_valid8); end
    checks++; if (o_bip_rst8 !== 1'b0 || o_cycle_count8 !== 8'hFF) begin errors++; $display("FAIL wdog_state: got bip_rst=%b count=%h expected 0/ff", o_bip_rst8, o_cycle_count8); end
    checks++; if (run8 - base !== 255) begin errors++; $display("FAIL wdog_run_cycles: got %0d expected 255", run8 - base); end
    i_tx_ready8 = 1'b1;
    b0 = o_tx_data8;
    @(posedge clk); #1;
    b1 = o_tx_data8;
    @(posedge clk); #1;
    i_tx_ready8 = 1'b0;
    checks++; if (b0 !== 8'h01 || b1 !== 8'hFF) begin errors++; $display("FAIL wdog_report: got %h %h expected 01 ff", b0, b1); end
    checks++; if (o_busy8 !== 1'b0 || o_tx_valid8 !== 1'b0) begin errors++; $display("FAIL wdog_idle: got busy=%b tx_valid=%b expected 0/0", o_busy8, o_tx_valid8); end
  endtask

  task automatic test_watchdog_tie();
    int n = 0;
    logic [7:0] b0, b1;
    i_start8 = 1'b1;
    @(posedge clk); #1;
    i_start8   = 1'b0;
    i_rx_data8 = 8'h00;
    i_rx_valid8 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    i_rx_valid8 = 1'b0;
    while (o_bip_rst8 !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (o_bip_rst8 !== 1'b1) begin errors++; $display("FAIL tie_release: got %b expected 1", o_bip_rst8); end
    repeat (254) begin @(posedge clk); #1; end
    i_bip_done8 = 1'b1;
    @(posedge clk); #1;
    i_bip_done8 = 1'b0;
    checks++; if (o_tx_valid8 !== 1'b1 || o_cycle_count8 !== 8'hFE) begin errors++; $display("FAIL tie_state: got tx_valid=%b count=%h expected 1/fe", o_tx_valid8, o_cycle_count8); end
    i_tx_ready8 = 1'b1;
    b0 = o_tx_data8;
    @(posedge clk); #1;
    b1 = o_tx_data8;
    @(posedge clk); #1;
    i_tx_ready8 = 1'b0;
    checks++; if (b0 !== 8'h00 || b1 !== 8'hFE) begin errors++; $display("FAIL tie_report: got %h %h expected 00 fe", b0, b1); end
  endtask

  task automatic test_reset_midway();
    logic [7:0] exp_b [5];
    int base;
    exp_b = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    tmo = 1'b0;
    start_session();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0 || o_rx_ready !== 1'b0 || o_prog_we !== 1'b0 || o_bip_rst !== 1'b0) begin
      errors++; $display("FAIL rst_instr_hi: got busy=%b ready=%b we=%b bip_rst=%b expected 0/0/0/0", o_busy, o_rx_ready, o_prog_we, o_bip_rst);
    end
    rst = 1'b1;
    base = wr_addr_q.size();
    start_session();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h22, 0);
    send_byte(8'h11, 0);
    wait_release();
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (wr_addr_q.size() - base !== 1 || wr_data_q[base] !== 16'h1122 || wr_addr_q[base] !== 11'd0) begin
      errors++; $display("FAIL rst_reload_write: got %0d writes data=%h addr=%0d expected 1/1122/0", wr_addr_q.size() - base, wr_data_q[base], wr_addr_q[base]);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_bip_rst !== 1'b0 || o_tx_valid !== 1'b0 || o_cycle_count !== 32'd0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_run: got bip_rst=%b tx_valid=%b count=%0d busy=%b expected 0/0/0/0", o_bip_rst, o_tx_valid, o_cycle_count, o_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    start_session();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    run_core(2);
    recv_report(5, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rpt[i] !== exp_b[i]) begin errors++; $display("FAIL rst_session_byte%0d: got %h expected %h", i, rpt[i], exp_b[i]); end
    end
    checks++; if (tmo || o_busy !== 1'b0) begin errors++; $display("FAIL rst_session_finish: got timeout=%b busy=%b expected 0/0", tmo, o_busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tmo = 1'b0;
    rst = 1'b0;
    i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_tx_ready = 1'b0; i_bip_done = 1'b0;
    i_start8 = 1'b0; i_rx_valid8 = 1'b0; i_rx_data8 = 8'h00; i_tx_ready8 = 1'b0; i_bip_done8 = 1'b0;
    test_reset();
    test_load_n3();
    test_zero_length();
    test_stall();
    test_len_clamp();
    test_watchdog();
    test_watchdog_tie();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
